// File: rtl/pc_next_if.sv
// pc_next_if: fetch-stage PC bus between the redirect sources and pc_next_unit.
// With EXC_VECTOR_EN defined it also carries Exception and Epc.
interface pc_next_if;
  logic        PcStall;
  logic        ImemReady;
  logic        Branch;
  logic [31:0] BranchOffset;
  logic        Jump;
  logic [27:0] JumpTarget;
  logic        JumpReg;
  logic [31:0] RegTarget;
  logic [31:0] Pc;
  logic [31:0] PcPlus4;
  logic        FetchValid;
  logic        AddrErr;
`ifdef EXC_VECTOR_EN
  logic        Exception;
  logic [31:0] Epc;
`endif
  modport master (
    output PcStall, ImemReady, Branch, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget,
`ifdef EXC_VECTOR_EN
    output Exception,
    input  Epc,
`endif
    input  Pc, PcPlus4, FetchValid, AddrErr
  );
  modport slave (
    input  PcStall, ImemReady, Branch, BranchOffset, Jump, JumpTarget, JumpReg, RegTarget,
`ifdef EXC_VECTOR_EN
    input  Exception,
    output Epc,
`endif
    output Pc, PcPlus4, FetchValid, AddrErr
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: MIPS fetch PC register and next-PC select with a one-deep redirect buffer.
// Optional exception entry (EXC_VECTOR parameter, Exception/Epc) is enabled by EXC_VECTOR_EN.
module pc_next_unit #(
`ifdef EXC_VECTOR_EN
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
`endif
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  pc_next_if.slave   bus
);
  logic [31:0] pc_q, pc_d, pend_q, pend_d, pc_plus4, redir_tgt;
  logic        fv_q, pend_v_q, pend_v_d, aerr_q, aerr_d, adv, redir;
  assign pc_plus4  = pc_q + 32'd4;
  assign redir     = bus.JumpReg | bus.Jump | bus.Branch;
  assign redir_tgt = bus.JumpReg ? {bus.RegTarget[31:2], 2'b00} :
                     bus.Jump    ? {pc_plus4[31:28], bus.JumpTarget} :
                                   pc_plus4 + bus.BranchOffset;
  assign adv       = fv_q & ~bus.PcStall & bus.ImemReady;
`ifdef EXC_VECTOR_EN
  logic [31:0] epc_q;
  logic        exc;
  assign exc = bus.Exception & fv_q;
`endif
  // A JR is accepted only while the buffer is empty, whether applied now or latched.
  always_comb begin
    pc_d     = adv ? (pend_v_q ? pend_q : redir ? redir_tgt : pc_plus4) : pc_q;
    pend_d   = (!adv && !pend_v_q && redir) ? redir_tgt : pend_q;
    pend_v_d = adv ? 1'b0 : (pend_v_q | redir);
    aerr_d   = bus.JumpReg & ~pend_v_q & (|bus.RegTarget[1:0]);
`ifdef EXC_VECTOR_EN
    if (exc) begin
      pc_d     = EXC_VECTOR;
      pend_v_d = 1'b0;
      aerr_d   = 1'b0;
    end
`endif
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      fv_q     <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      fv_q     <= 1'b1;
      aerr_q   <= aerr_d;
    end
  end
`ifdef EXC_VECTOR_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) epc_q <= '0;
    else if (exc) epc_q <= pc_q;
  end
  assign bus.Epc = epc_q;
`endif
  assign bus.Pc         = pc_q;
  assign bus.PcPlus4    = pc_plus4;
  assign bus.FetchValid = fv_q;
  assign bus.AddrErr    = aerr_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed fetch/redirect scenarios plus random traffic against a behavioural PC model.
// Define EXC_VECTOR_EN to also exercise the exception entry.
module tb_pc_next_unit;
  localparam logic [31:0] EXC_ADDR = 32'h8000_0180;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  pc_next_if bus();
  pc_next_unit dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_pc, m_pend, m_epc;
  logic        m_fv, m_pv, m_aerr;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // {valid, target} of the highest-priority redirect requested this cycle
  function automatic logic [32:0] redirect_req();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (bus.JumpReg) return {1'b1, bus.RegTarget[31:2], 2'b00};
    if (bus.Jump)    return {1'b1, p4[31:28], bus.JumpTarget};
    if (bus.Branch)  return {1'b1, p4 + bus.BranchOffset};
    return 33'd0;
  endfunction
  function automatic bit exc_now();
`ifdef EXC_VECTOR_EN
    return bus.Exception && m_fv;
`else
    return 1'b0;
`endif
  endfunction
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc <= 32'h0; m_pend <= 32'h0; m_epc <= 32'h0;
      m_fv <= 1'b0; m_pv <= 1'b0; m_aerr <= 1'b0;
    end else begin
      m_fv   <= 1'b1;
      m_aerr <= !exc_now() && bus.JumpReg && !m_pv && (bus.RegTarget[1:0] != 2'b00);
      if (exc_now()) begin
        m_pc <= EXC_ADDR; m_epc <= m_pc; m_pv <= 1'b0;
      end else if (m_fv && !bus.PcStall && bus.ImemReady) begin
        m_pc <= m_pv ? m_pend : (redirect_req() >> 32) != 0 ? redirect_req() : m_pc + 32'd4;
        m_pv <= 1'b0;
      end else if (!m_pv && redirect_req() >> 32 != 0) begin
        m_pv <= 1'b1; m_pend <= redirect_req();
      end
    end
  end
  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_pc", bus.Pc, m_pc);
      check("model_pc_plus4", bus.PcPlus4, m_pc + 32'd4);
      check("model_fetch_valid", {31'd0, bus.FetchValid}, {31'd0, m_fv});
      check("model_addr_err", {31'd0, bus.AddrErr}, {31'd0, m_aerr});
`ifdef EXC_VECTOR_EN
      check("model_epc", bus.Epc, m_epc);
`endif
    end
  end
  task automatic cyc();
    @(negedge Clk);
  endtask
  task automatic idle();
    bus.PcStall = 1'b0; bus.ImemReady = 1'b1;
    bus.Branch = 1'b0; bus.BranchOffset = '0;
    bus.Jump = 1'b0; bus.JumpTarget = '0;
    bus.JumpReg = 1'b0; bus.RegTarget = '0;
`ifdef EXC_VECTOR_EN
    bus.Exception = 1'b0;
`endif
  endtask
  task automatic jr(input logic [31:0] addr);
    bus.JumpReg = 1'b1; bus.RegTarget = addr;
    cyc();
    bus.JumpReg = 1'b0;
  endtask
  initial begin
    idle();
    repeat (2) cyc();
    check("reset_pc", bus.Pc, 32'h0);
    check("reset_fetch_valid", {31'd0, bus.FetchValid}, 32'd0);
    check("reset_addr_err", {31'd0, bus.AddrErr}, 32'd0);
    Reset_n = 1'b1;
    chk_en  = 1'b1;
    cyc();
    check("t1_first_fv", {31'd0, bus.FetchValid}, 32'd1);
    check("t1_pc0", bus.Pc, 32'h0);
    cyc(); check("t1_pc4", bus.Pc, 32'h4);
    cyc(); check("t1_pc8", bus.Pc, 32'h8);
    cyc(); check("t1_pcc", bus.Pc, 32'hC);
    jr(32'h1000_0040);
    check("t2_setup", bus.Pc, 32'h1000_0040);
    bus.Jump = 1'b1; bus.JumpTarget = 28'h0000_400;
    cyc(); bus.Jump = 1'b0;
    check("t2_jump", bus.Pc, 32'h1000_0400);
    jr(32'h100);
    bus.Branch = 1'b1; bus.BranchOffset = 32'hFFFF_FFF0;
    cyc(); bus.Branch = 1'b0;
    check("t3_branch_back", bus.Pc, 32'hF4);
    jr(32'hFFFF_FFFC);
    cyc();
    check("t3_wrap", bus.Pc, 32'h0);
    jr(32'h100);
    bus.PcStall = 1'b1;
    bus.Branch = 1'b1; bus.BranchOffset = 32'hFC;
    cyc(); bus.Branch = 1'b0;
    bus.Jump = 1'b1; bus.JumpTarget = 28'h300;
    cyc(); bus.Jump = 1'b0;
    cyc();
    check("t4_held", bus.Pc, 32'h100);
    bus.PcStall = 1'b0;
    cyc(); check("t4_pending_applied", bus.Pc, 32'h200);
    cyc(); check("t4_jump_dropped", bus.Pc, 32'h204);
    bus.JumpReg = 1'b1; bus.Jump = 1'b1; bus.Branch = 1'b1;
    bus.RegTarget = 32'h0000_1006; bus.JumpTarget = 28'h300; bus.BranchOffset = 32'h40;
    cyc(); idle();
    check("t5_priority", bus.Pc, 32'h1004);
    check("t5_addr_err_on", {31'd0, bus.AddrErr}, 32'd1);
    cyc();
    check("t5_addr_err_off", {31'd0, bus.AddrErr}, 32'd0);
    check("t5_next", bus.Pc, 32'h1008);
`ifdef EXC_VECTOR_EN
    jr(32'h40);
    bus.PcStall = 1'b1; bus.Exception = 1'b1;
    cyc(); idle();
    check("t6_exc_pc", bus.Pc, 32'h8000_0180);
    check("t6_epc", bus.Epc, 32'h40);
`endif
    for (int i = 0; i < 600; i++) begin
      bus.PcStall      = ($urandom % 4) == 0;
      bus.ImemReady    = ($urandom % 4) != 0;
      bus.Branch       = ($urandom % 5) == 0;
      bus.BranchOffset = $urandom & 32'hFFFF_FFFC;
      bus.Jump         = ($urandom % 7) == 0;
      bus.JumpTarget   = 28'($urandom) & 28'hFFF_FFFC;
      bus.JumpReg      = ($urandom % 8) == 0;
      bus.RegTarget    = $urandom;
`ifdef EXC_VECTOR_EN
      bus.Exception    = ($urandom % 40) == 0;
`endif
      cyc();
    end
    idle();
    cyc();
    bus.PcStall = 1'b1;
    bus.Branch = 1'b1; bus.BranchOffset = 32'h80;
    cyc(); bus.Branch = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    check("t6_async_pc", bus.Pc, 32'h0);
    check("t6_async_fv", {31'd0, bus.FetchValid}, 32'd0);
    check("t6_async_aerr", {31'd0, bus.AddrErr}, 32'd0);
    cyc();
    Reset_n = 1'b1; bus.PcStall = 1'b0;
    cyc();
    check("t6_release_fv", {31'd0, bus.FetchValid}, 32'd1);
    check("t6_pending_lost", bus.Pc, 32'h0);
    cyc();
    check("t6_seq", bus.Pc, 32'h4);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
